// File: rtl/dmem_ctrl.sv
// Handshaked data memory for the multicycle MIPS core: byte/half/word loads and
// stores, sign/zero extension, programmable wait states and misalignment errors.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  mask,
  input  logic        signed_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [1:0]              lane_q, lane_d;
  logic [1:0]              mask_q, mask_d;
  logic                    sext_q, sext_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    mem_we_s;
  logic [3:0]              be_s;
  logic [31:0]             wlane_s;
  logic [31:0]             rd_word_s;
  logic                    unused_addr_s;

  logic [31:0]             mem_q [DEPTH];

  function automatic logic misaligned(input logic [1:0] m, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if (m[1]) begin
      r = (lo != 2'b00);
    end else if (m[0]) begin
      r = lo[0];
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] m, input logic [1:0] lane);
    logic [3:0] be;
    if (m[1]) begin
      be = 4'b1111;
    end else if (m[0]) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
    end else begin
      be = 4'b0001 << lane;
    end
    return be;
  endfunction

  // Replicate the sub-word store data onto every lane; byte enables pick the target.
  function automatic logic [31:0] lane_data(input logic [1:0] m, input logic [31:0] d);
    logic [31:0] r;
    if (m[1]) begin
      r = d;
    end else if (m[0]) begin
      r = {2{d[15:0]}};
    end else begin
      r = {4{d[7:0]}};
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] m,
                                               input logic [1:0] lane, input logic sext);
    logic [31:0] r;
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? word[31:16] : word[15:0];
    b = word[{lane, 3'b000} +: 8];
    if (m[1]) begin
      r = word;
    end else if (m[0]) begin
      r = sext ? {{16{h[15]}}, h} : {16'h0000, h};
    end else begin
      r = sext ? {{24{b[7]}}, b} : {24'h000000, b};
    end
    return r;
  endfunction

  assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];
  assign rd_word_s     = mem_q[idx_q];
  assign be_s          = byte_en(mask_q, lane_q);
  assign wlane_s       = lane_data(mask_q, wdata_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    mask_d   = mask_q;
    sext_d   = sext_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misaligned(mask, addr[1:0])) begin
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = S_RESP;
          end else begin
            we_d    = we;
            idx_d   = addr[ADDR_WIDTH+1:2];
            lane_d  = addr[1:0];
            mask_d  = mask;
            sext_d  = signed_ext;
            wdata_d = wdata;
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = 1'b0;
          if (we_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = load_extract(rd_word_s, mask_q, lane_q, sext_q);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      mask_q  <= 2'b00;
      sext_q  <= 1'b0;
      wdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // A store whose completing edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_q[idx_q][8*k +: 8] <= wlane_s[8*k +: 8];
        end
      end
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: a vector table on a WAIT_CYCLES=1
// instance plus hand sequences for zero/max wait states and reset mid-store.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  mask;
  logic        sext;
  logic [31:0] wdata;
  logic        req_a, req_b, req_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_a, err_b, err_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        busy_a, busy_b, busy_c;

  int total;
  int bad;

  dmem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .mask(mask),
    .signed_ext(sext), .wdata(wdata), .ready(ready_a), .err(err_a),
    .rdata(rdata_a), .busy(busy_a));

  dmem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .mask(mask),
    .signed_ext(sext), .wdata(wdata), .ready(ready_b), .err(err_b),
    .rdata(rdata_b), .busy(busy_b));

  dmem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(15)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .we(we), .addr(addr), .mask(mask),
    .signed_ext(sext), .wdata(wdata), .ready(ready_c), .err(err_c),
    .rdata(rdata_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  mask;
    logic        sext;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, tag, act, exp);
    end
  endtask

  task automatic set_req(input int inst, input logic v);
    case (inst)
      0: req_a = v;
      1: req_b = v;
      default: req_c = v;
    endcase
  endtask

  task automatic get_out(input int inst, output logic r, output logic e,
                         output logic [31:0] d, output logic b);
    case (inst)
      0: begin r = ready_a; e = err_a; d = rdata_a; b = busy_a; end
      1: begin r = ready_b; e = err_b; d = rdata_b; b = busy_b; end
      default: begin r = ready_c; e = err_c; d = rdata_c; b = busy_c; end
    endcase
  endtask

  // One request on the chosen instance; inputs are scrambled right after accept.
  task automatic access(input int inst, input logic w, input logic [31:0] a, input logic [1:0] m,
                        input logic s, input logic [31:0] d, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd, input int tag);
    int          n;
    logic        r, e, b;
    logic [31:0] q;
    @(negedge clk);
    we = w; addr = a; mask = m; sext = s; wdata = d;
    set_req(inst, 1'b1);
    @(negedge clk);
    set_req(inst, 1'b0);
    we = ~w; addr = ~a; mask = ~m; sext = ~s; wdata = ~d;
    n = 1;
    get_out(inst, r, e, q, b);
    while (!r && n < 60) begin
      @(negedge clk);
      n++;
      get_out(inst, r, e, q, b);
    end
    chk("latency", tag, n, exp_lat);
    chk("err", tag, {31'd0, e}, {31'd0, exp_err});
    chk("rdata", tag, q, exp_rd);
    @(negedge clk);
    get_out(inst, r, e, q, b);
    chk("ready_pulse_busy", tag, {30'd0, r, b}, 32'd0);
    chk("err_hold", tag, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_rdy;
    int          rdy_at;
    logic [31:0] rd_at;
    total = 0;
    bad   = 0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    we = 1'b0; addr = 32'd0; mask = 2'b00; sext = 1'b0; wdata = 32'd0;

    vt[0]  = '{1'b1, 32'h20,  2'b10, 1'b0, 32'h11223344, 1'b0, 32'h00000000};
    vt[1]  = '{1'b1, 32'h30,  2'b10, 1'b0, 32'h55667788, 1'b0, 32'h00000000};
    vt[2]  = '{1'b1, 32'h40,  2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00000000};
    vt[3]  = '{1'b1, 32'h50,  2'b10, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h00000000};
    vt[4]  = '{1'b1, 32'h10,  2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vt[5]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vt[6]  = '{1'b1, 32'h21,  2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 32'hDEADBEEF};
    vt[7]  = '{1'b0, 32'h21,  2'b00, 1'b1, 32'h00000000, 1'b0, 32'hFFFFFF80};
    vt[8]  = '{1'b0, 32'h21,  2'b00, 1'b0, 32'h00000000, 1'b0, 32'h00000080};
    vt[9]  = '{1'b0, 32'h20,  2'b10, 1'b0, 32'h00000000, 1'b0, 32'h11228044};
    vt[10] = '{1'b0, 32'h23,  2'b00, 1'b1, 32'h00000000, 1'b0, 32'h00000011};
    vt[11] = '{1'b1, 32'h32,  2'b01, 1'b0, 32'h12348001, 1'b0, 32'h00000011};
    vt[12] = '{1'b0, 32'h32,  2'b01, 1'b1, 32'h00000000, 1'b0, 32'hFFFF8001};
    vt[13] = '{1'b0, 32'h32,  2'b01, 1'b0, 32'h00000000, 1'b0, 32'h00008001};
    vt[14] = '{1'b0, 32'h30,  2'b10, 1'b0, 32'h00000000, 1'b0, 32'h80017788};
    vt[15] = '{1'b0, 32'h30,  2'b01, 1'b1, 32'h00000000, 1'b0, 32'h00007788};
    vt[16] = '{1'b0, 32'h41,  2'b10, 1'b0, 32'h00000000, 1'b1, 32'h00007788};
    vt[17] = '{1'b1, 32'h43,  2'b01, 1'b0, 32'h0000BEEF, 1'b1, 32'h00007788};
    vt[18] = '{1'b1, 32'h42,  2'b11, 1'b0, 32'h0BADF00D, 1'b1, 32'h00007788};
    vt[19] = '{1'b0, 32'h40,  2'b10, 1'b0, 32'h00000000, 1'b0, 32'hCAFEF00D};
    vt[20] = '{1'b0, 32'h43,  2'b00, 1'b1, 32'h00000000, 1'b0, 32'hFFFFFFCA};
    vt[21] = '{1'b0, 32'h410, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vt[22] = '{1'b1, 32'h12,  2'b00, 1'b0, 32'h0000005A, 1'b0, 32'hDEADBEEF};
    vt[23] = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h00000000, 1'b0, 32'hDE5ABEEF};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 0, {ready_a, err_a, busy_a, 29'd0}, 32'd0);
    chk("reset_rdata", 0, rdata_a, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      access(0, vt[i].we, vt[i].addr, vt[i].mask, vt[i].sext, vt[i].wdata,
             vt[i].exp_err ? 1 : 3, vt[i].exp_err, vt[i].exp_rd, i);
    end

    // Zero wait states
    access(1, 1'b1, 32'h04, 2'b10, 1'b0, 32'h0BADF00D, 2, 1'b0, 32'h00000000, 100);
    access(1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h00000000, 2, 1'b0, 32'h0BADF00D, 101);
    access(1, 1'b0, 32'h06, 2'b10, 1'b0, 32'h00000000, 1, 1'b1, 32'h0BADF00D, 102);

    // Maximum wait states, then req pulses while busy must be ignored
    access(2, 1'b1, 32'h00, 2'b10, 1'b0, 32'h0F0F0F0F, 17, 1'b0, 32'h00000000, 200);
    @(negedge clk);
    we = 1'b0; addr = 32'h00; mask = 2'b10; sext = 1'b0;
    req_c = 1'b1;
    n_rdy = 0;
    rdy_at = 0;
    rd_at = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_c = (c >= 3 && c <= 10);
      chk("w15_busy", c, {31'd0, busy_c}, {31'd0, (c <= 17)});
      if (ready_c) begin
        n_rdy++;
        rdy_at = c;
        rd_at  = rdata_c;
      end
    end
    req_c = 1'b0;
    chk("w15_ready_count", 201, n_rdy, 1);
    chk("w15_ready_cycle", 201, rdy_at, 17);
    chk("w15_rdata", 201, rd_at, 32'h0F0F0F0F);

    // Reset lands on the WAIT-exit edge of a store; a req during reset is dropped
    @(negedge clk);
    we = 1'b1; addr = 32'h50; mask = 2'b10; wdata = 32'h12345678;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    chk("rst_mid_outputs", 300, {ready_a, err_a, busy_a, 29'd0}, 32'd0);
    chk("rst_mid_rdata", 300, rdata_a, 32'd0);
    rst = 1'b0;
    req_a = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rst_no_ready", 301 + c, {30'd0, ready_a, busy_a}, 32'd0);
    end
    access(0, 1'b0, 32'h50, 2'b10, 1'b0, 32'h00000000, 3, 1'b0, 32'hAAAAAAAA, 310);
    access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h00000000, 3, 1'b0, 32'hDE5ABEEF, 311);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
